// File: rtl/mult_seq_if.sv
// Handshake and operand/result bundle between the EX stage and the iterative multiplier mult_seq.
interface mult_seq_if #(
    parameter int WIDTH = 32
);
    logic             start;
    logic             flush;
    logic [WIDTH-1:0] op_a;
    logic [WIDTH-1:0] op_b;
    logic             stall;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] result;

    modport master (
        output start, flush, op_a, op_b,
        input  stall, busy, done, result
    );

    modport slave (
        input  start, flush, op_a, op_b,
        output stall, busy, done, result
    );
endinterface

// File: rtl/mult_seq.sv
// Shift-add multiplier sequencer: one partial-product step per cycle, low WIDTH product bits out with a one-cycle done.
// Optional MULT_EARLY_EXIT_EN: finish as soon as the remaining multiplier bits are all zero.
module mult_seq #(
    parameter int WIDTH = 32
) (
    input  logic     clk,
    input  logic     rst_n,
    mult_seq_if.slave mul_if
);
    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE
    } state_t;

    state_t           r_state;
    state_t           w_next;
    logic [WIDTH-1:0] r_mcand;
    logic [WIDTH-1:0] r_mplier;
    logic [WIDTH-1:0] r_acc;
    logic [CW-1:0]    r_cnt;
    logic             w_capture;
    logic             w_last;

    assign w_capture = (r_state == S_IDLE) && mul_if.start && !mul_if.flush;

`ifdef MULT_EARLY_EXIT_EN
    // Once every remaining multiplier bit is zero the accumulator can no longer change.
    assign w_last = (r_cnt == LAST_CNT) || (r_mplier[WIDTH-1:1] == '0);
`else
    assign w_last = (r_cnt == LAST_CNT);
`endif

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // NOTE: w_next gets its default before the case so no path leaves it unassigned (no latch).
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (w_capture) w_next = S_RUN;
            S_RUN:   if (w_last) w_next = S_DONE;
            S_DONE:  w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
        if (mul_if.flush) w_next = S_IDLE;
    end

    // A flushed step leaves the datapath untouched, so result keeps the partial sum.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_mcand  <= '0;
            r_mplier <= '0;
            r_acc    <= '0;
            r_cnt    <= '0;
        end else if (w_capture) begin
            r_mcand  <= mul_if.op_a;
            r_mplier <= mul_if.op_b;
            r_acc    <= '0;
            r_cnt    <= '0;
        end else if ((r_state == S_RUN) && !mul_if.flush) begin
            r_acc    <= r_acc + (r_mplier[0] ? r_mcand : '0);
            r_mcand  <= r_mcand << 1;
            r_mplier <= r_mplier >> 1;
            r_cnt    <= r_cnt + 1'b1;
        end
    end

    assign mul_if.stall  = w_capture || (r_state == S_RUN);
    assign mul_if.busy   = (r_state == S_RUN);
    assign mul_if.done   = (r_state == S_DONE);
    assign mul_if.result = r_acc;
endmodule

// File: tb/tb_mult_seq.sv
// Directed bench for mult_seq (WIDTH=32); latency expectations follow MULT_EARLY_EXIT_EN when defined.
module tb_mult_seq;
    localparam int WIDTH = 32;

    logic clk;
    logic rst_n;
    int   n_checks;
    int   n_pass;

    mult_seq_if #(.WIDTH(WIDTH)) u_if ();

    mult_seq #(.WIDTH(WIDTH)) u_dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .mul_if (u_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [WIDTH-1:0] got, input logic [WIDTH-1:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    // Cycles from the start cycle T to the done cycle.
    function automatic int exp_lat(input logic [WIDTH-1:0] b);
`ifdef MULT_EARLY_EXIT_EN
        int hi;
        hi = 1;
        for (int i = 0; i < WIDTH; i++) if (b[i]) hi = i + 1;
        return hi + 1;
`else
        return WIDTH + 1;
`endif
    endfunction

    task automatic do_mult(input string tag, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                           input logic [WIDTH-1:0] exp);
        int lat;
        int bad;
        lat = exp_lat(b);
        bad = 0;
        @(negedge clk);
        u_if.start = 1'b1;
        u_if.op_a  = a;
        u_if.op_b  = b;
        #1;
        check({tag, "_stall_T"}, WIDTH'(u_if.stall), WIDTH'(1));
        for (int k = 1; k <= lat; k++) begin
            @(negedge clk);
            if (k == 1) u_if.start = 1'b0;
            #1;
            if (u_if.done !== (k == lat) || u_if.stall !== (k < lat) || u_if.busy !== (k < lat)) begin
                if (bad == 0) begin
                    check({tag, "_timing"}, WIDTH'({u_if.done, u_if.stall, u_if.busy}),
                          WIDTH'({k == lat, k < lat, k < lat}));
                end
                bad++;
            end
            if (k == lat) check({tag, "_result"}, u_if.result, exp);
        end
        if (bad == 0) check({tag, "_timing"}, WIDTH'({u_if.done, u_if.stall, u_if.busy}), WIDTH'(3'b100));
        @(negedge clk);
        #1;
        check({tag, "_idle_after"}, WIDTH'({u_if.done, u_if.busy}), WIDTH'(0));
        check({tag, "_hold"}, u_if.result, exp);
    endtask

    initial begin
        int lat;
        int ndone;
        int first;
        int second;
        logic [WIDTH-1:0] res2;
        n_checks = 0;
        n_pass   = 0;
        rst_n = 1'b0;
        u_if.start = 1'b0;
        u_if.flush = 1'b0;
        u_if.op_a  = '0;
        u_if.op_b  = '0;

        #12;
        check("reset_busy",   WIDTH'(u_if.busy),  WIDTH'(0));
        check("reset_done",   WIDTH'(u_if.done),  WIDTH'(0));
        check("reset_stall",  WIDTH'(u_if.stall), WIDTH'(0));
        check("reset_result", u_if.result,        WIDTH'(0));
        @(negedge clk);
        rst_n = 1'b1;

        do_mult("m3x5",    32'd3,          32'd5,          32'd15);
        do_mult("mff",     32'hFFFFFFFF,   32'hFFFFFFFF,   32'h00000001);
        do_mult("mwrap",   32'h80000000,   32'd2,          32'h00000000);
        do_mult("mneg",    32'hFFFFFFFD,   32'd5,          32'hFFFFFFF1);
        do_mult("mb4",     32'd7,          32'd4,          32'd28);
        do_mult("mb0",     32'd1234,       32'd0,          32'd0);
        do_mult("mbtop",   32'd1,          32'h80000000,   32'h80000000);

        // start held through DONE: exactly one recapture, in the following IDLE cycle.
        lat = exp_lat(32'd6);
        ndone = 0; first = 0; second = 0; res2 = '0;
        @(negedge clk);
        u_if.start = 1'b1;
        u_if.op_a  = 32'd7;
        u_if.op_b  = 32'd6;
        for (int k = 1; k <= 2 * lat + 2; k++) begin
            @(negedge clk);
            if (k == lat + 2) u_if.start = 1'b0;
            #1;
            if (u_if.done) begin
                ndone++;
                if (first == 0) first = k;
                else begin
                    second = k;
                    res2 = u_if.result;
                end
            end
            if (k == lat) check("held_done_stall", WIDTH'(u_if.stall), WIDTH'(0));
            if (k == lat + 1) check("held_recapture", WIDTH'({u_if.stall, u_if.busy}), WIDTH'(2'b10));
        end
        check("held_ndone",  WIDTH'(ndone),  WIDTH'(2));
        check("held_first",  WIDTH'(first),  WIDTH'(lat));
        check("held_second", WIDTH'(second), WIDTH'(2 * lat + 1));
        check("held_result", res2, 32'd42);

        // Flush mid-RUN at T+10.
        @(negedge clk);
        u_if.start = 1'b1;
        u_if.op_a  = 32'd3;
        u_if.op_b  = 32'hFFFF0005;
        ndone = 0;
        for (int k = 1; k <= 11; k++) begin
            @(negedge clk);
            u_if.start = 1'b0;
            u_if.flush = (k == 10);
            #1;
            if (u_if.done) ndone++;
        end
        check("flush_state", WIDTH'({u_if.busy, u_if.stall, u_if.done}), WIDTH'(0));
        check("flush_acc",   u_if.result, 32'd15);
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            #1;
            if (u_if.done) ndone++;
        end
        check("flush_no_done", WIDTH'(ndone), WIDTH'(0));

        // Asynchronous reset mid-RUN at T+5.
        @(negedge clk);
        u_if.start = 1'b1;
        u_if.op_a  = 32'd3;
        u_if.op_b  = 32'hFFFF0005;
        for (int k = 1; k <= 5; k++) begin
            @(negedge clk);
            u_if.start = 1'b0;
        end
        #1;
        check("pre_rst_busy", WIDTH'(u_if.busy), WIDTH'(1));
        #1 rst_n = 1'b0;
        #1;
        check("rst_busy",   WIDTH'(u_if.busy),  WIDTH'(0));
        check("rst_done",   WIDTH'(u_if.done),  WIDTH'(0));
        check("rst_result", u_if.result,        WIDTH'(0));
        @(negedge clk);
        rst_n = 1'b1;
        do_mult("m7x6", 32'd7, 32'd6, 32'd42);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule

// File: doc/mult_seq.md
# mult_seq

Iterative shift-add multiplier sequencer for the execute stage. It replaces the single-cycle combinational `busA * srcB` product: when EX decodes the multiply ALU control (`aluCtrl == 4'b1111`), this block captures the operands. It stalls the front of the pipeline while it runs one partial-product step per cycle, then presents the low WIDTH bits of the product for one cycle with `done`. The EX result mux selects `result` when `done` is high.

## Interface
- `WIDTH`, 32, operand, product and result width (≥2).
- `clk`  in  1  rising-edge clock.
- `rst_n`  in  1  asynchronous, active-low reset.
- `start`  in  1  EX holds a multiply. Level; sampled only in IDLE.
- `flush`  in  1  synchronous abort (branch taken / squash).
- `opA`  in  WIDTH  multiplicand (busA).
- `opB`  in  WIDTH  multiplier (srcB after the aluSrc mux).
- `stall`  out  1  freeze PC/IF/ID/EX pipeline registers.
- `busy`  out  1  state is RUN.
- `done`  out  1  `result` valid this cycle; high for exactly one cycle.
- `result`  out  WIDTH  low WIDTH bits of opA*opB. Identical for signed and unsigned operands.

## Operation
- States: IDLE, RUN, DONE. Registers: `mcand` (WIDTH), `mplier` (WIDTH), `acc` (WIDTH), `cnt` (`$clog2(WIDTH)` bits).
- IDLE and `start` and not `flush`: capture `mcand<=opA`, `mplier<=opB`, `acc<=0`, `cnt<=0`, then go to RUN.
- RUN step: `acc <= acc + (mplier[0] ? mcand : 0)` (mod 2^WIDTH), `mcand <= mcand<<1`, `mplier <= mplier>>1`, `cnt <= cnt+1`.
- RUN exits to DONE on the step where `cnt == WIDTH-1`.
- DONE: `done=1` and `result=acc`. Next state is IDLE unconditionally. `start` is ignored in DONE because the same instruction is still in EX.
- `stall = (IDLE & start & ~flush) | RUN`. It is combinational and is low in DONE so the multiply retires that cycle.
- `result` is driven from `acc` at all times. It holds its value in IDLE until the next capture clears it.
- `flush` takes priority over every other transition. In any state it forces IDLE at the next edge. `done` is not asserted for the aborted operation and `acc` is left unchanged.
- A `start` held across the IDLE following DONE is a new multiply and is accepted.

## Timing
- Reset values: state IDLE, `acc/mcand/mplier/cnt=0`, `busy=0`, `done=0`, `result=0`. `stall` follows its equation, so it is 0 while `start=0`.
- `start` is seen in IDLE at cycle T:
  - `stall`=1 during cycles T through T+WIDTH.
  - RUN occupies cycles T+1 through T+WIDTH.
  - DONE (`done`=1, `stall`=0) occupies cycle T+WIDTH+1.
  - Total EX occupancy is WIDTH+2 cycles.
- Asserting `rst_n` in any state returns to reset values immediately, with no `done`.
- No overflow or carry flag is produced. Upper product bits are discarded.

## Configuration
- `MULT_EARLY_EXIT_EN` defined:
  - RUN also exits to DONE on the step where the shifted multiplier is zero (`mplier>>1 == 0`).
  - A capture with `opB==0` performs one RUN step and then goes to DONE.
  - Results are unchanged; latency becomes (position of highest set bit of opB, counted from 1, or 1 if opB==0) + 2 cycles.
- `MULT_EARLY_EXIT_EN` undefined: fixed WIDTH RUN cycles regardless of operands.

## Test plan
- WIDTH=32, opA=3, opB=5, `start` at T:
  - `stall` high T..T+32.
  - `done`=1 with `result`=15 only at T+33.
  - Without the macro, `busy` high T+1..T+32.
- opA=opB=32'hFFFFFFFF gives `result`=32'h00000001. opA=32'h80000000, opB=2 gives `result`=0 (wrap).
- `start` held high through DONE: no second capture in DONE; a new capture occurs the following IDLE cycle. Check `done` pulses once per operation.
- Assert `flush` at T+10 mid-RUN: state is IDLE at T+11, `stall`=0 (with `start`=0), and `done` is never asserted.
- Drop `rst_n` at T+5 asynchronously: `busy`, `done` and `result` go to 0 before the next edge. After release, a new multiply 7*6 gives 42.
- With `MULT_EARLY_EXIT_EN` defined:
  - opB=4 gives `done` at T+4 with result 4*opA.
  - opB=0 gives `done` at T+2 with result 0.
  - opB=32'h80000000 gives `done` at T+33.
